wb_copy_master: RTL
===================

WB_COPY_MASTER -- requirements
Module: wb_copy_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles waited for wbm_ack_i per request.
REQ-002 SHALL have parameter LEN_W, default 16: width of the word-count input.
REQ-003 SHALL have port wb_clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  one-cycle copy request, sampled only in IDLE.
REQ-006 SHALL have port src_addr  in  32  byte address of the first source word; bits [1:0] ignored.
REQ-007 SHALL have port dst_addr  in  32  byte address of the first destination word; bits [1:0] ignored.
REQ-008 SHALL have port len  in  LEN_W  number of 32-bit words to copy.
REQ-009 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-010 SHALL have port done  out  1  one-cycle pulse when a copy ends.
REQ-011 SHALL have port err  out  1  timeout flag; sticky until the next accepted start.
REQ-012 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone classic initiator controls.
REQ-013 SHALL have ports wbm_sel_o  out  4, wbm_adr_o  out  32, wbm_dat_o  out  32  Wishbone request fields.
REQ-014 SHALL have ports wbm_dat_i  in  32 and wbm_ack_i  in  1  Wishbone responder return path.

Function
REQ-015 SHALL implement the states IDLE, RD, RD_GAP, WR, WR_GAP and DONE.
REQ-016 SHALL, in IDLE on start=1, latch src_addr, dst_addr and len, clear err, and go to RD (or to DONE when len=0).
REQ-017 SHALL, in RD, drive cyc=stb=1, we=0, sel=4'hF and adr=current source address, holding them until ack.
REQ-018 SHALL, on RD ack, capture wbm_dat_i into a 32-bit holding register and go to RD_GAP.
REQ-019 SHALL, in WR, drive cyc=stb=1, we=1, sel=4'hF, adr=current destination address and dat=holding register, holding them until ack.
REQ-020 SHALL, on WR ack, increment both addresses by 4 (wrapping modulo 2^32), decrement the remaining count, and go to WR_GAP.
REQ-021 SHALL deassert cyc and stb for exactly one cycle in RD_GAP and in WR_GAP.
REQ-022 SHALL leave RD_GAP for WR.
REQ-023 SHALL leave WR_GAP for RD while the remaining count is nonzero, otherwise for DONE.
REQ-024 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-025 SHALL drive busy as (state != IDLE).
REQ-026 SHALL ignore start in every state except IDLE.
REQ-027 SHALL ignore wbm_ack_i in every state except RD and WR.
REQ-028 SHALL drive cyc=stb=we=0 and sel=0 outside RD and WR; adr and dat hold their last values there.
REQ-029 SHALL have a minimum per-word cost of 4 cycles when the responder acks in the first request cycle.
REQ-030 SHALL accept start in the DONE-to-IDLE cycle's successor, i.e. back-to-back copies are separated by one IDLE cycle.

Reset
REQ-031 SHALL, while rst_n=0, force state=IDLE and busy=done=err=cyc=stb=we=0, sel=0, adr=0, dat=0, count=0 and holding register=0.
REQ-032 SHALL abort any transfer when reset is asserted mid-copy, dropping cyc/stb immediately and issuing no done pulse.

Configuration
REQ-033 SHALL, with WB_COPY_TIMEOUT_EN defined, count cycles in RD/WR from request start, reloading to 0 on each new request.
REQ-034 SHALL, with WB_COPY_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYC without ack, drop cyc/stb, set err and go to DONE; an ack arriving in that same cycle wins and no error is flagged.
REQ-035 SHALL, without WB_COPY_TIMEOUT_EN, wait indefinitely for ack, tie err to 0 and include no counter logic.

Structure
REQ-036 SHALL place the state enum and the constant WORD_BYTES=4 in the package wb_copy_pkg.
REQ-037 SHALL implement the ack watchdog as the sub-module wb_ack_timer (inputs: clear, run; output: expired), instantiated only under WB_COPY_TIMEOUT_EN.

Verification
REQ-038 SHALL cover: src=0x3800_0000, dst=0x3800_0100, len=3, zero-wait responder -> reads 0x..000/004/008 and writes 0x..100/104/108 with matching data, done pulses once, 12 bus-active/gap cycles.
REQ-039 SHALL cover: len=0 -> no cyc ever asserted; busy high for 1 cycle; done pulses in the cycle after start.
REQ-040 SHALL cover: responder inserts 5 wait cycles on each ack -> stb held stable with constant adr/dat throughout the waits, and data copied correctly.
REQ-041 SHALL cover: start pulsed while busy -> ignored, with latched len unchanged.
REQ-042 SHALL cover: src=0xFFFF_FFFC, len=2 -> the second read address is 0x0000_0000.
REQ-043 SHALL cover: with WB_COPY_TIMEOUT_EN and TIMEOUT_CYC=8, no ack -> cyc drops after 8 cycles, err=1, done pulses; the next start clears err.

Source files
------------

// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone word-copy master.
package wb_copy_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_GAP,
    WR,
    WR_GAP,
    DONE
  } state_t;

endpackage

// File: rtl/wb_ack_timer.sv
// Ack watchdog: counts request cycles from 0 and flags expiry in the cycle
// that completes TIMEOUT_CYC cycles without leaving the request.
module wb_ack_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic wb_clk_i,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = run && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone classic master copying len 32-bit words from src to dst, one read
// then one write per word with a one-cycle bus gap after each access.
// Optional ack watchdog and err flag: define WB_COPY_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start
// RD     | read request on the bus, waiting for ack
// RD_GAP | bus idle one cycle, read word held
// WR     | write request on the bus, waiting for ack
// WR_GAP | bus idle one cycle, decide next word or finish
// DONE   | done pulse, back to IDLE
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int LEN_W       = 16
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  state_t state, state_nxt;

  logic [31:0]      src_q, dst_q, hold_q, adr_q, dat_q;
  logic [LEN_W-1:0] cnt_q;
  logic             start_ok, req, tmo;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^{src_addr[1:0], dst_addr[1:0]};
  assign start_ok = (state == IDLE) && start;
  assign req      = (state == RD) || (state == WR);

`ifdef WB_COPY_TIMEOUT_EN
  logic tmo_exp, err_q;

  wb_ack_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ack_timer (
    .wb_clk_i (wb_clk_i),
    .rst_n    (rst_n),
    .clear    (!req),
    .run      (req),
    .expired  (tmo_exp)
  );

  // An ack in the expiry cycle wins over the timeout.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n)                          err_q <= 1'b0;
    else if (start_ok)                   err_q <= 1'b0;
    else if (req && !wbm_ack_i && tmo_exp) err_q <= 1'b1;
  end

  assign tmo = tmo_exp;
  assign err = err_q;
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wbm_cyc_o = 1'b0;
    wbm_stb_o = 1'b0;
    wbm_we_o  = 1'b0;
    wbm_sel_o = 4'h0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RD;
      RD: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_sel_o = 4'hF;
        if (wbm_ack_i) state_nxt = RD_GAP;
        else if (tmo)  state_nxt = DONE;
      end
      RD_GAP:  state_nxt = WR;
      WR: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_sel_o = 4'hF;
        if (wbm_ack_i) state_nxt = WR_GAP;
        else if (tmo)  state_nxt = DONE;
      end
      WR_GAP:  state_nxt = (cnt_q != '0) ? RD : DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // adr/dat are loaded as each request begins so they stay put through gaps.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
      adr_q  <= '0;
      dat_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_q <= {src_addr[31:2], 2'b00};
          dst_q <= {dst_addr[31:2], 2'b00};
          cnt_q <= len;
          if (len != '0) adr_q <= {src_addr[31:2], 2'b00};
        end
        RD:     if (wbm_ack_i) hold_q <= wbm_dat_i;
        RD_GAP: begin
          adr_q <= dst_q;
          dat_q <= hold_q;
        end
        WR: if (wbm_ack_i) begin
          src_q <= src_q + WORD_BYTES;
          dst_q <= dst_q + WORD_BYTES;
          cnt_q <= cnt_q - 1'b1;
        end
        WR_GAP: if (cnt_q != '0) adr_q <= src_q;
        default: ;
      endcase
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule
